// File: rtl/xbar_route_fifo_if.sv
// rtl/xbar_route_fifo_if.sv - lane-vector input and per-bank output handshake bundle
// master drives the product lanes and bank pops; slave is the crossbar.
interface xbar_route_fifo_if #(
  parameter int NUM_SRC = 4,
  parameter int NUM_DST = 32,
  parameter int DATA_W  = 32,
  parameter int COORD_W = 5,
  parameter int K_W     = 4
);
  logic [NUM_SRC-1:0]         in_valid;
  logic [NUM_SRC*DATA_W-1:0]  in_data;
  logic [NUM_SRC*COORD_W-1:0] in_row;
  logic [NUM_SRC*COORD_W-1:0] in_col;
  logic [NUM_SRC*K_W-1:0]     in_k;
  logic                       in_ready;
  logic [NUM_DST-1:0]         out_valid;
  logic [NUM_DST-1:0]         out_ready;
  logic [NUM_DST*DATA_W-1:0]  out_data;
  logic [NUM_DST*COORD_W-1:0] out_x;
  logic [NUM_DST*COORD_W-1:0] out_y;
  logic [NUM_DST*K_W-1:0]     out_k;

  modport master (
    output in_valid, in_data, in_row, in_col, in_k, out_ready,
    input  in_ready, out_valid, out_data, out_x, out_y, out_k
  );

  modport slave (
    input  in_valid, in_data, in_row, in_col, in_k, out_ready,
    output in_ready, out_valid, out_data, out_x, out_y, out_k
  );
endinterface

// File: rtl/xbar_route_fifo.sv
// rtl/xbar_route_fifo.sv - routes tagged products into per-bank FWFT FIFOs
// Optional sticky overflow flag: define XBAR_OVF_CHECK_EN.
module xbar_route_fifo #(
  parameter int         NUM_SRC    = 4,
  parameter int         NUM_DST    = 32,
  parameter int         FIFO_DEPTH = 8,
  parameter int         DATA_W     = 32,
  parameter int         COORD_W    = 5,
  parameter int         K_W        = 4,
  parameter logic [2:0] ACC_STATE  = 3'd2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          state_pe,
  input  logic                sparse,
  input  logic                in_partial,
  xbar_route_fifo_if.slave    bus,
  output logic                busy,
  output logic                empty,
  output logic                partial_c,
  output logic                overflow_err
);
  localparam int BANK_W = $clog2(NUM_DST);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = DATA_W + 2 * COORD_W + K_W;
  localparam logic [CNT_W-1:0]   FULL_FREE = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   NSRC_FREE = CNT_W'(NUM_SRC);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [K_W-1:0]     K_ONE     = K_W'(1);

  logic [ENT_W-1:0] mem [NUM_DST][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr   [NUM_DST];
  logic [PTR_W-1:0] wr_ptr   [NUM_DST];
  logic [CNT_W-1:0] free_cnt [NUM_DST];

  logic [BANK_W-1:0] lane_bank  [NUM_SRC];
  logic [PTR_W-1:0]  lane_slot  [NUM_SRC];
  logic [ENT_W-1:0]  lane_entry [NUM_SRC];
  logic [NUM_SRC-1:0] lane_we;
  logic [CNT_W-1:0]  push_cnt [NUM_DST];
  logic [CNT_W-1:0]  push_num [NUM_DST];
  logic [NUM_DST-1:0] pop;
  logic [NUM_DST-1:0] bank_valid;
  logic in_ready;
`ifdef XBAR_OVF_CHECK_EN
  logic ovf_event;
`endif

  // Admission uses registered free counts only, so in_ready never depends on inputs.
  always_comb begin
    busy  = 1'b0;
    empty = 1'b1;
    for (int b = 0; b < NUM_DST; b++) begin
      busy          = busy | (free_cnt[b] < NSRC_FREE);
      empty         = empty & (free_cnt[b] == FULL_FREE);
      bank_valid[b] = (free_cnt[b] != FULL_FREE);
      pop[b]        = bank_valid[b] & bus.out_ready[b];
    end
    in_ready = ~busy;
  end

  // Lanes claim consecutive slots per bank in ascending lane order; a lane that
  // would exceed the bank's free space is dropped, earlier lanes are kept.
  always_comb begin
    logic [COORD_W-1:0] y, x;
    logic [K_W-1:0]     k;
    lane_we = '0;
`ifdef XBAR_OVF_CHECK_EN
    ovf_event = 1'b0;
`endif
    for (int b = 0; b < NUM_DST; b++) push_cnt[b] = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      y = bus.in_row[n*COORD_W +: COORD_W] - COORD_ONE;
      x = bus.in_col[n*COORD_W +: COORD_W] - COORD_ONE;
      k = sparse ? (bus.in_k[n*K_W +: K_W] - K_ONE) : bus.in_k[n*K_W +: K_W];
      lane_bank[n]  = y[BANK_W-1:0];
      lane_entry[n] = {bus.in_data[n*DATA_W +: DATA_W], x, y, k};
      lane_slot[n]  = wr_ptr[lane_bank[n]] + push_cnt[lane_bank[n]][PTR_W-1:0];
      if (bus.in_valid[n]) begin
        if (push_cnt[lane_bank[n]] < free_cnt[lane_bank[n]]) begin
          lane_we[n] = in_ready;
          push_cnt[lane_bank[n]] = push_cnt[lane_bank[n]] + CNT_ONE;
        end else begin
`ifdef XBAR_OVF_CHECK_EN
          ovf_event = 1'b1;
`endif
        end
      end
    end
    for (int b = 0; b < NUM_DST; b++) push_num[b] = in_ready ? push_cnt[b] : '0;
  end

  always_ff @(posedge clock) begin
    for (int n = 0; n < NUM_SRC; n++) begin
      if (!reset && lane_we[n]) mem[lane_bank[n]][lane_slot[n]] <= lane_entry[n];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < NUM_DST; b++) begin
        rd_ptr[b]   <= '0;
        wr_ptr[b]   <= '0;
        free_cnt[b] <= FULL_FREE;
      end
      partial_c <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_DST; b++) begin
        wr_ptr[b]   <= wr_ptr[b] + push_num[b][PTR_W-1:0];
        rd_ptr[b]   <= rd_ptr[b] + PTR_W'(pop[b]);
        free_cnt[b] <= free_cnt[b] - push_num[b] + CNT_W'(pop[b]);
      end
      partial_c <= (state_pe == ACC_STATE) ? (partial_c | in_partial) : 1'b0;
    end
  end

`ifdef XBAR_OVF_CHECK_EN
  logic ovf_q;
  always_ff @(posedge clock) begin
    if (reset)          ovf_q <= 1'b0;
    else if (ovf_event) ovf_q <= 1'b1;
  end
  assign overflow_err = ovf_q;
`else
  assign overflow_err = 1'b0;
`endif

  logic [NUM_DST*DATA_W-1:0]  out_data_v;
  logic [NUM_DST*COORD_W-1:0] out_x_v, out_y_v;
  logic [NUM_DST*K_W-1:0]     out_k_v;

  always_comb begin
    out_data_v = '0;
    out_x_v    = '0;
    out_y_v    = '0;
    out_k_v    = '0;
    for (int b = 0; b < NUM_DST; b++) begin
      {out_data_v[b*DATA_W +: DATA_W], out_x_v[b*COORD_W +: COORD_W],
       out_y_v[b*COORD_W +: COORD_W], out_k_v[b*K_W +: K_W]} = mem[b][rd_ptr[b]];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = bank_valid;
  assign bus.out_data  = out_data_v;
  assign bus.out_x     = out_x_v;
  assign bus.out_y     = out_y_v;
  assign bus.out_k     = out_k_v;
endmodule

// File: tb/tb_xbar_route_fifo.sv
// tb/tb_xbar_route_fifo.sv - directed self-checking bench for xbar_route_fifo
module tb_xbar_route_fifo;
`ifdef XBAR_OVF_CHECK_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] state_pe;
  logic       sparse;
  logic       in_partial;
  logic       busy, empty, partial_c, overflow_err;
  int         checks = 0;
  int         errors = 0;
  int         sent, recv;

  xbar_route_fifo_if #(.NUM_SRC(4), .NUM_DST(32), .DATA_W(32), .COORD_W(5), .K_W(4)) bus ();

  xbar_route_fifo #(
    .NUM_SRC(4), .NUM_DST(32), .FIFO_DEPTH(8), .DATA_W(32),
    .COORD_W(5), .K_W(4), .ACC_STATE(3'd2)
  ) dut (
    .clock(clock), .reset(reset), .state_pe(state_pe), .sparse(sparse),
    .in_partial(in_partial), .bus(bus.slave), .busy(busy), .empty(empty),
    .partial_c(partial_c), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_row   = '0;
    bus.in_col   = '0;
    bus.in_k     = '0;
  endtask

  task automatic set_lane(input int n, input int row, input int col, input int k,
                          input logic [31:0] data);
    logic [4:0] r5, c5;
    logic [3:0] k4;
    r5 = 5'(row);
    c5 = 5'(col);
    k4 = 4'(k);
    bus.in_row[n*5 +: 5]   = r5;
    bus.in_col[n*5 +: 5]   = c5;
    bus.in_k[n*4 +: 4]     = k4;
    bus.in_data[n*32 +: 32] = data;
    bus.in_valid[n]        = 1'b1;
  endtask

  function automatic logic [31:0] head_data(input int b);
    return bus.out_data[b*32 +: 32];
  endfunction

  initial begin
    reset = 1'b1; state_pe = 3'd0; sparse = 1'b0; in_partial = 1'b0;
    clear_in();
    bus.out_ready = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_partial", 64'(partial_c), 64'd0);
    check("rst_ovf", 64'(overflow_err), 64'd0);

    // single lane: row 3, col 7, k 5, sparse -> bank 2, y 2, x 6, k 4
    sparse = 1'b1;
    set_lane(0, 3, 7, 5, 32'hA5);
    tick();
    clear_in();
    check("single_valid", 64'(bus.out_valid), 64'h4);
    check("single_y", 64'(bus.out_y[2*5 +: 5]), 64'd2);
    check("single_x", 64'(bus.out_x[2*5 +: 5]), 64'd6);
    check("single_k", 64'(bus.out_k[2*4 +: 4]), 64'd4);
    check("single_data", 64'(head_data(2)), 64'hA5);
    check("single_not_empty", 64'(empty), 64'd0);
    bus.out_ready[2] = 1'b1;
    tick();
    bus.out_ready = '0;
    check("single_pop_empty", 64'(empty), 64'd1);
    check("single_pop_valid", 64'(bus.out_valid), 64'd0);

    // collision: all four lanes to bank 0
    sparse = 1'b0;
    for (int n = 0; n < 4; n++) set_lane(n, 1, 1, 0, 32'(n + 1));
    tick();
    check("coll1_busy", 64'(busy), 64'd0);
    check("coll1_ready", 64'(bus.in_ready), 64'd1);
    check("coll1_head", 64'(head_data(0)), 64'd1);
    for (int n = 0; n < 4; n++) set_lane(n, 1, 1, 0, 32'(n + 5));
    tick();
    check("coll2_busy", 64'(busy), 64'd1);
    check("coll2_ready", 64'(bus.in_ready), 64'd0);
    check("coll2_valid", 64'(bus.out_valid), 64'd1);
    for (int n = 0; n < 4; n++) set_lane(n, 1, 1, 0, 32'(n + 9));
    bus.out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("coll_pop_head", 64'(head_data(0)), 64'(i + 2));
      check("coll_pop_ready", 64'(bus.in_ready), (i == 3) ? 64'd1 : 64'd0);
    end
    bus.out_ready[0] = 1'b0;
    tick();
    clear_in();
    check("coll3_busy", 64'(busy), 64'd1);
    check("coll3_head", 64'(head_data(0)), 64'd5);
    bus.out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("coll_drain", 64'(head_data(0)), 64'(i + 5));
      tick();
    end
    bus.out_ready = '0;
    check("coll_empty", 64'(empty), 64'd1);

    // wrap: 20 items through bank 5 with out_ready toggling
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      @(negedge clock);
      if (bus.out_valid[5] && (cyc % 2 == 1)) begin
        check("wrap_data", 64'(head_data(5)), 64'(32'hC000 + recv));
        recv++;
      end
      bus.out_ready[5] = (cyc % 2 == 1);
      clear_in();
      if (sent < 20) begin
        set_lane(0, 6, 2, 0, 32'hC000 + 32'(sent));
        if (bus.in_ready) sent++;
      end
    end
    check("wrap_count", 64'(recv), 64'd20);
    clear_in();
    tick();
    bus.out_ready = '0;
    check("wrap_empty", 64'(empty), 64'd1);

    // partial flag
    state_pe = 3'd0;
    in_partial = 1'b1;
    tick();
    check("partial_other_state", 64'(partial_c), 64'd0);
    in_partial = 1'b0;
    state_pe = 3'd2;
    tick();
    check("partial_pre", 64'(partial_c), 64'd0);
    in_partial = 1'b1;
    tick();
    in_partial = 1'b0;
    check("partial_set", 64'(partial_c), 64'd1);
    repeat (10) tick();
    check("partial_hold", 64'(partial_c), 64'd1);
    state_pe = 3'd0;
    tick();
    check("partial_clear", 64'(partial_c), 64'd0);

    // k select and modulo coordinates
    sparse = 1'b0;
    set_lane(1, 2, 1, 5, 32'h11);
    set_lane(2, 0, 0, 0, 32'h22);
    tick();
    clear_in();
    check("k_valid", 64'(bus.out_valid), 64'h8000_0002);
    check("k_dense", 64'(bus.out_k[1*4 +: 4]), 64'd5);
    check("k_y1", 64'(bus.out_y[1*5 +: 5]), 64'd1);
    check("k_x1", 64'(bus.out_x[1*5 +: 5]), 64'd0);
    check("mod_y", 64'(bus.out_y[31*5 +: 5]), 64'd31);
    check("mod_x", 64'(bus.out_x[31*5 +: 5]), 64'd31);
    check("mod_data", 64'(head_data(31)), 64'h22);
    sparse = 1'b1;
    set_lane(0, 0, 0, 0, 32'h33);
    bus.out_ready[31] = 1'b1;
    tick();
    clear_in();
    bus.out_ready = '0;
    check("mod_k_sparse", 64'(bus.out_k[31*4 +: 4]), 64'd15);
    check("mod_push_pop", 64'(head_data(31)), 64'h33);
    bus.out_ready = '1;
    tick();
    bus.out_ready = '0;
    check("k_empty", 64'(empty), 64'd1);

    // overflow: push to a full bank while in_ready is low
    sparse = 1'b0;
    for (int n = 0; n < 4; n++) set_lane(n, 1, 1, 0, 32'h101 + 32'(n));
    tick();
    for (int n = 0; n < 4; n++) set_lane(n, 1, 1, 0, 32'h105 + 32'(n));
    tick();
    check("ovf_full_busy", 64'(busy), 64'd1);
    check("ovf_pre", 64'(overflow_err), 64'd0);
    for (int n = 0; n < 4; n++) set_lane(n, 1, 1, 0, 32'hDEAD);
    tick();
    clear_in();
    check("ovf_flag", 64'(overflow_err), 64'(OVF_EN));
    tick();
    check("ovf_sticky", 64'(overflow_err), 64'(OVF_EN));
    bus.out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_data", 64'(head_data(0)), 64'(32'h101 + i));
      tick();
    end
    bus.out_ready = '0;
    check("ovf_drained", 64'(empty), 64'd1);

    // reset mid-stream
    for (int n = 0; n < 4; n++) set_lane(n, 4, 1, 0, 32'h200 + 32'(n));
    tick();
    clear_in();
    check("mid_not_empty", 64'(empty), 64'd0);
    reset = 1'b1;
    bus.out_ready = '1;
    tick();
    reset = 1'b0;
    bus.out_ready = '0;
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ovf", 64'(overflow_err), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xbar_route_fifo.md
Name: xbar_route_fifo

Overview:
- Parametrised successor of the PE multiplier-to-accumulator crossbar.
- Routes up to NUM_SRC products per cycle, each tagged with (row, col, k) coordinates, into NUM_DST per-bank FIFOs. The bank is selected by the low bits of the row coordinate.
- Adds an input ready/backpressure handshake and per-bank valid/ready output handshakes toward the accumulate buffer. Also adds configurable widths and depths, and a sticky partial-sum flag.

Parameters:
NUM_SRC, 4, multiplier lanes presented per cycle
NUM_DST, 32, output banks; power of 2, >= 2
FIFO_DEPTH, 8, entries per bank FIFO; power of 2, >= NUM_SRC
DATA_W, 32, product data width
COORD_W, 5, row/col coordinate width
K_W, 4, output-channel index width
ACC_STATE, 2, controller state code in which the partial flag accumulates

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high reset
state_pe  in  3  PE controller state
sparse  in  1  1: k = k_in-1; 0: k = k_in
in_valid  in  NUM_SRC  per-lane product valid
in_data  in  NUM_SRC*DATA_W  products
in_row  in  NUM_SRC*COORD_W  1-based row coordinate
in_col  in  NUM_SRC*COORD_W  1-based column coordinate
in_k  in  NUM_SRC*K_W  channel index
in_partial  in  1  partial-sum marker from the multiplier stage
in_ready  out  1  block accepts the lane vector this cycle
out_valid  out  NUM_DST  bank head valid
out_ready  in  NUM_DST  accumulate buffer takes the bank head
out_data  out  NUM_DST*DATA_W  bank head data
out_x  out  NUM_DST*COORD_W  head column (0-based)
out_y  out  NUM_DST*COORD_W  head row (0-based)
out_k  out  NUM_DST*K_W  head channel
busy  out  1  any bank has fewer than NUM_SRC free entries
empty  out  1  all banks empty
partial_c  out  1  sticky partial flag
overflow_err  out  1  see Optional Feature

Behaviour:
- Reset: all FIFOs empty; pointers 0; free counts = FIFO_DEPTH; partial_c = 0; overflow_err = 0. Consequences: out_valid = 0, empty = 1, busy = 0, in_ready = 1.
- Reset mid-operation discards all queued entries; no output handshake completes in the reset cycle.
- Transform per lane:
  - y = row-1, x = col-1, k as selected by sparse; all arithmetic is modulo the field width.
  - Bank = y[log2(NUM_DST)-1:0].
- Input handshake:
  - in_ready = !busy; it is derived combinationally from registered free counts only.
  - Lane n is accepted when in_valid[n] && in_ready.
  - When in_ready = 0, all lanes are ignored and upstream holds its data.
- Multiple accepted lanes targeting one bank in the same cycle are all written in ascending lane order, consecutive slots, all in that cycle.
- Output: each bank is first-word-fall-through.
  - out_valid[b] = bank b non-empty; the head fields are driven from the registered FIFO at rd_ptr.
  - Pop occurs on out_valid[b] && out_ready[b].
  - out_ready is ignored while out_valid = 0.
- Latency: a lane accepted on edge t is visible at its bank head after edge t (cycle t+1) if the bank was empty. Pushes never bypass combinationally.
- A same-cycle push and pop on one bank are both honoured.
  - free_next = free - pushes + pop.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Ordering within a bank is strict FIFO.
- Because busy uses pre-pop counts, a bank at exactly NUM_SRC-1 free entries stalls input even if it pops that cycle (conservative, one-cycle bubble).
- partial_c:
  - While state_pe == ACC_STATE: set when in_partial = 1, otherwise held.
  - In any other state: cleared on the next edge.
- empty = AND over banks of (free == FIFO_DEPTH), using registered state.

Optional Feature:
- Macro XBAR_OVF_CHECK_EN.
- When defined:
  - A push that would exceed FIFO_DEPTH (upstream violating in_ready) is dropped; the lanes already written that cycle are kept.
  - overflow_err sets sticky and is cleared only by reset.
- When not defined:
  - The same drop logic still protects FIFO integrity.
  - overflow_err is tied 0 and its register is not built.

Test Plan:
- Reset, then idle -> empty=1, busy=0, in_ready=1, out_valid=0 in all banks.
- Single lane: lane0 row=3, col=7, k=5, data=0xA5, sparse=1 -> next cycle out_valid[2]=1, out_y=2, out_x=6, out_k=4, out_data=0xA5. Pop with out_ready[2]=1 -> empty=1 the cycle after.
- Collision: NUM_SRC=4, all lanes row=1 with data 1,2,3,4 -> bank0 pops 1,2,3,4 in order; busy=1 while bank0 free < 4 (FIFO_DEPTH=8, after two such vectors). in_ready=0 blocks a third vector until pops restore 4 free entries.
- Wrap: push and pop 20 items through bank 5 with out_ready toggling 1/0 -> all 20 are received in order, and pointers wrap without loss.
- Partial flag: state_pe=2, then in_partial pulses once -> partial_c=1 held over 10 cycles; state_pe=0 -> partial_c=0 next cycle. sparse=0, k=5 -> out_k=5.
- XBAR_OVF_CHECK_EN defined: force pushes to a full bank with in_ready=0 -> entries are dropped, overflow_err=1 sticky, and queued data is unchanged. Reset mid-stream -> all banks empty next cycle and overflow_err=0.
